// File: rtl/axi_hp_mem_pkg.sv
// rtl/axi_hp_mem_pkg.sv - Shared types and address helpers for the HP-port memory responder
package axi_hp_mem_pkg;

    localparam int AXI_AW = 32;

    typedef enum logic [1:0] {FIXED = 2'b00, INCR = 2'b01, WRAP = 2'b10} burst_t;
    typedef enum logic [1:0] {OKAY = 2'b00, EXOKAY = 2'b01, SLVERR = 2'b10, DECERR = 2'b11} resp_t;
    typedef enum logic [1:0] {W_IDLE, W_DATA, W_RESP} wr_state_t;
    typedef enum logic [0:0] {R_IDLE, R_DATA} rd_state_t;

    function automatic logic [AXI_AW-1:0] next_addr(input logic [AXI_AW-1:0] addr,
                                                    input logic [2:0] size,
                                                    input logic [1:0] burst);
        if (burst == FIXED) return addr;
        return addr + (AXI_AW'(1) << size);
    endfunction

    // Only FIXED and INCR with beats no wider than the 64-bit bus are served.
    function automatic logic burst_unsupported(input logic [2:0] size, input logic [1:0] burst);
        return (size > 3'd3) || !(burst == FIXED || burst == INCR);
    endfunction

endpackage

// File: rtl/axi_hp_mem_ram.sv
// rtl/axi_hp_mem_ram.sv - Simple dual-port RAM, byte-enabled write port, registered read port
module axi_hp_mem_ram #(
    parameter int AD = 10,
    parameter int DW = 64
) (
    input  logic            clk,
    input  logic            we,
    input  logic [AD-1:0]   waddr,
    input  logic [DW/8-1:0] wstrb,
    input  logic [DW-1:0]   wdata,
    input  logic            re,
    input  logic [AD-1:0]   raddr,
    output logic [DW-1:0]   rdata
);

    logic [DW-1:0] mem [2**AD];

    always_ff @(posedge clk) begin
        if (we) begin
            for (int b = 0; b < DW/8; b++) begin
                if (wstrb[b]) mem[waddr][b*8 +: 8] <= wdata[b*8 +: 8];
            end
        end
    end

    // Read-first: a read on the write's commit edge sees the old word.
    always_ff @(posedge clk) begin
        if (re) rdata <= mem[raddr];
    end

endmodule

// File: rtl/axi_hp_mem_responder.sv
// rtl/axi_hp_mem_responder.sv - AXI3 HP-port slave answering bursts from an internal word memory
module axi_hp_mem_responder
    import axi_hp_mem_pkg::*;
#(
    parameter int            DW   = 64,
    parameter int            AW   = AXI_AW,
    parameter int            IW   = 6,
    parameter int            LW   = 4,
    parameter int            AD   = 10,
    parameter logic [AW-1:0] BASE = '0
) (
    input  logic            ACLK,
    input  logic            ARESETn,
    input  logic [AW-1:0]   AWADDR,
    input  logic [IW-1:0]   AWID,
    input  logic [LW-1:0]   AWLEN,
    input  logic [2:0]      AWSIZE,
    input  logic [1:0]      AWBURST,
    input  logic [1:0]      AWLOCK,
    input  logic [3:0]      AWCACHE,
    input  logic [2:0]      AWPROT,
    input  logic [3:0]      AWQOS,
    input  logic            AWVALID,
    output logic            AWREADY,
    input  logic [DW-1:0]   WDATA,
    input  logic [DW/8-1:0] WSTRB,
    input  logic [IW-1:0]   WID,
    input  logic            WLAST,
    input  logic            WVALID,
    output logic            WREADY,
    output logic [IW-1:0]   BID,
    output logic [1:0]      BRESP,
    output logic            BVALID,
    input  logic            BREADY,
    input  logic [AW-1:0]   ARADDR,
    input  logic [IW-1:0]   ARID,
    input  logic [LW-1:0]   ARLEN,
    input  logic [2:0]      ARSIZE,
    input  logic [1:0]      ARBURST,
    input  logic [1:0]      ARLOCK,
    input  logic [3:0]      ARCACHE,
    input  logic [2:0]      ARPROT,
    input  logic [3:0]      ARQOS,
    input  logic            ARVALID,
    output logic            ARREADY,
    output logic [DW-1:0]   RDATA,
    output logic [IW-1:0]   RID,
    output logic [1:0]      RRESP,
    output logic            RLAST,
    output logic            RVALID,
    input  logic            RREADY
);

    function automatic logic in_range(input logic [AW-1:0] addr);
        return ((addr - BASE) >> (AD + 3)) == '0;
    endfunction

    function automatic logic [AD-1:0] word_of(input logic [AW-1:0] addr);
        return AD'((addr - BASE) >> 3);
    endfunction

    logic unused_inputs;
    assign unused_inputs = ^{AWLOCK, AWCACHE, AWPROT, AWQOS, ARLOCK, ARCACHE, ARPROT, ARQOS, WID};

    wr_state_t     w_state;
    logic [IW-1:0] w_id;
    logic [AW-1:0] w_addr;
    logic [LW-1:0] w_len, w_beat;
    logic [2:0]    w_size;
    logic [1:0]    w_burst;
    logic          w_berr, w_err;
    logic          w_hs, w_last_beat, w_beat_err, w_we;

    assign w_hs        = WVALID && WREADY;
    assign w_last_beat = (w_beat == w_len);
    assign w_beat_err  = w_berr || !in_range(w_addr) || (WLAST != w_last_beat);
    assign w_we        = w_hs && !w_beat_err;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            w_state <= W_IDLE;
            AWREADY <= 1'b0;
            WREADY  <= 1'b0;
            BVALID  <= 1'b0;
            BID     <= '0;
            BRESP   <= OKAY;
            w_id    <= '0;
            w_addr  <= '0;
            w_len   <= '0;
            w_beat  <= '0;
            w_size  <= '0;
            w_burst <= '0;
            w_berr  <= 1'b0;
            w_err   <= 1'b0;
        end else begin
            case (w_state)
                W_IDLE: begin
                    if (!AWREADY) begin
                        AWREADY <= 1'b1;
                    end else if (AWVALID) begin
                        AWREADY <= 1'b0;
                        WREADY  <= 1'b1;
                        w_id    <= AWID;
                        w_addr  <= AWADDR;
                        w_len   <= AWLEN;
                        w_size  <= AWSIZE;
                        w_burst <= AWBURST;
                        w_beat  <= '0;
                        w_berr  <= burst_unsupported(AWSIZE, AWBURST);
                        w_err   <= 1'b0;
                        w_state <= W_DATA;
                    end
                end
                W_DATA: begin
                    if (w_hs) begin
                        w_addr <= next_addr(w_addr, w_size, w_burst);
                        w_beat <= w_beat + 1'b1;
                        w_err  <= w_err || w_beat_err;
                        // The beat count, not WLAST, ends the burst.
                        if (w_last_beat) begin
                            WREADY  <= 1'b0;
                            BVALID  <= 1'b1;
                            BID     <= w_id;
                            BRESP   <= (w_err || w_beat_err) ? SLVERR : OKAY;
                            w_state <= W_RESP;
                        end
                    end
                end
                W_RESP: begin
                    if (BREADY) begin
                        BVALID  <= 1'b0;
                        AWREADY <= 1'b1;
                        w_state <= W_IDLE;
                    end
                end
                default: w_state <= W_IDLE;
            endcase
        end
    end

    rd_state_t     r_state;
    logic [AW-1:0] r_addr, r_addr_nxt, r_launch_addr;
    logic [LW-1:0] r_len, r_beat, r_beat_nxt;
    logic [2:0]    r_size;
    logic [1:0]    r_burst;
    logic          r_berr, ar_hs, r_hs, r_launch;
    logic [DW-1:0] ram_rdata;

    assign ar_hs         = ARVALID && ARREADY;
    assign r_hs          = RVALID && RREADY;
    assign r_addr_nxt    = next_addr(r_addr, r_size, r_burst);
    assign r_beat_nxt    = r_beat + 1'b1;
    // The next beat is fetched on the edge that retires the current one, so beats never bubble.
    assign r_launch      = ar_hs || (r_hs && !RLAST);
    assign r_launch_addr = ar_hs ? ARADDR : r_addr_nxt;
    assign RDATA         = (RVALID && RRESP == OKAY) ? ram_rdata : '0;

    always_ff @(posedge ACLK or negedge ARESETn) begin
        if (!ARESETn) begin
            r_state <= R_IDLE;
            ARREADY <= 1'b0;
            RVALID  <= 1'b0;
            RLAST   <= 1'b0;
            RID     <= '0;
            RRESP   <= OKAY;
            r_addr  <= '0;
            r_len   <= '0;
            r_beat  <= '0;
            r_size  <= '0;
            r_burst <= '0;
            r_berr  <= 1'b0;
        end else begin
            case (r_state)
                R_IDLE: begin
                    if (!ARREADY) begin
                        ARREADY <= 1'b1;
                    end else if (ARVALID) begin
                        ARREADY <= 1'b0;
                        RVALID  <= 1'b1;
                        RID     <= ARID;
                        RLAST   <= (ARLEN == '0);
                        RRESP   <= (burst_unsupported(ARSIZE, ARBURST) || !in_range(ARADDR)) ? SLVERR : OKAY;
                        r_addr  <= ARADDR;
                        r_len   <= ARLEN;
                        r_size  <= ARSIZE;
                        r_burst <= ARBURST;
                        r_beat  <= '0;
                        r_berr  <= burst_unsupported(ARSIZE, ARBURST);
                        r_state <= R_DATA;
                    end
                end
                R_DATA: begin
                    if (r_hs) begin
                        if (RLAST) begin
                            RVALID  <= 1'b0;
                            RLAST   <= 1'b0;
                            RRESP   <= OKAY;
                            ARREADY <= 1'b1;
                            r_state <= R_IDLE;
                        end else begin
                            r_addr <= r_addr_nxt;
                            r_beat <= r_beat_nxt;
                            RLAST  <= (r_beat_nxt == r_len);
                            RRESP  <= (r_berr || !in_range(r_addr_nxt)) ? SLVERR : OKAY;
                        end
                    end
                end
                default: r_state <= R_IDLE;
            endcase
        end
    end

    axi_hp_mem_ram #(.AD(AD), .DW(DW)) u_ram (
        .clk   (ACLK),
        .we    (w_we),
        .waddr (word_of(w_addr)),
        .wstrb (WSTRB),
        .wdata (WDATA),
        .re    (r_launch),
        .raddr (word_of(r_launch_addr)),
        .rdata (ram_rdata)
    );

endmodule

// File: doc/axi_hp_mem_responder.md
# axi_hp_mem_responder

Synthesizable AXI3 slave that answers the Zynq HP-port master interface (64-bit data, 6-bit ID, 4-bit length) from an internal word-addressed memory. It stands in place of the PS DDR behind `S_AXI_HP0`/`S_AXI_HP1` in simulation benches and in loopback builds, so DMA-style masters in the PL receive real handshakes and real data instead of tied-off ready/valid lines. Read and write channels run independent burst state machines.

## Interface
- `DW` 64, data width; fixed to 64 for HP ports.
- `AW` 32, address width.
- `IW` 6, ID width.
- `LW` 4, burst length field width (AXI3, 1–16 beats).
- `AD` 10, log2 of memory depth in 64-bit words.
- `BASE` 32'h0000_0000, byte address of memory word 0.
- `ACLK` in 1: single clock, all logic rising-edge.
- `ARESETn` in 1: asynchronous, active-low reset.
- `AWADDR`/`AWID`/`AWLEN`/`AWSIZE`/`AWBURST` in AW/IW/LW/3/2: write address. `AWVALID` in 1, `AWREADY` out 1. `AWLOCK`/`AWCACHE`/`AWPROT`/`AWQOS` in: ignored.
- `WDATA`/`WSTRB`/`WID`/`WLAST`/`WVALID` in DW/DW/8/IW/1/1; `WREADY` out 1.
- `BID` out IW, `BRESP` out 2, `BVALID` out 1, `BREADY` in 1.
- `ARADDR`/`ARID`/`ARLEN`/`ARSIZE`/`ARBURST` in AW/IW/LW/3/2: read address. `ARVALID` in 1, `ARREADY` out 1. `ARLOCK`/`ARCACHE`/`ARPROT`/`ARQOS` in: ignored.
- `RDATA` out DW, `RID` out IW, `RRESP` out 2, `RLAST` out 1, `RVALID` out 1, `RREADY` in 1.

## Operation
- Write FSM: `W_IDLE` (AWREADY=1) → AW handshake latches id, addr, len, size, burst, clears beat counter and error flag → `W_DATA` (WREADY=1). Each W handshake writes the bytes enabled by WSTRB into word `(addr-BASE)>>3`, then advances the address. On beat `AWLEN` → `W_RESP` (BVALID=1, BID = latched id). B handshake → `W_IDLE`.
- Read FSM: `R_IDLE` (ARREADY=1) → AR handshake latches fields → `R_DATA`. RVALID holds until the R handshake. RLAST=1 on beat `ARLEN`. The R handshake on the last beat → `R_IDLE`.
- Address step: INCR adds `1<<SIZE`; FIXED adds 0; WRAP is unsupported. SIZE > 3 is also unsupported. Address arithmetic is AW-bit, modulo 2^AW.
- Error flag, set by any of: WRAP burst, SIZE > 3, any beat whose address falls outside [BASE, BASE + 2^AD·8), or WLAST disagreeing with the beat count on any beat.
  - Error beats do not write memory. A read error beat returns RDATA=0 with RRESP=SLVERR (2'b10).
  - BRESP is SLVERR if the error flag was set on any beat, otherwise OKAY.
  - The beat counter is authoritative: the burst always ends after `AWLEN+1` beats, regardless of WLAST.
- WID and the ID on RID/BID are echoed, not checked.
- Memory is not reset; its contents survive `ARESETn`.

## Timing
- Reset values: AWREADY, WREADY, BVALID, ARREADY, RVALID, RLAST = 0. BID, RID, BRESP, RRESP, RDATA = 0. Both FSMs are in IDLE.
- AWREADY and ARREADY rise on the first ACLK edge after ARESETn deasserts.
- Write path:
  - AW accepted at edge N → WREADY=1 from N+1.
  - A W beat accepted at edge M is committed to memory at edge M.
  - Last W beat at edge M → BVALID=1 from M+1.
  - AWREADY returns one cycle after the B handshake.
- Read path:
  - AR accepted at edge N → RVALID with beat 0 from N+1 (one-cycle memory latency).
  - With RREADY held high, beats are back-to-back: one per cycle, no bubbles.
  - With RREADY low, RDATA/RID/RRESP/RLAST stay stable while RVALID=1.
- Concurrency: read and write bursts run concurrently. A read of the same word in the cycle the write commits returns the old data. A write beat accepted at edge M is visible to a read beat launched at M+1 or later.
- ARESETn asserted mid-burst: all outputs go to reset values immediately (asynchronously) and the burst is abandoned. Partial writes already committed stay in memory.

## Structure
- Package `axi_hp_mem_pkg`:
  - `burst_t` enum: FIXED/INCR/WRAP.
  - `resp_t` constants: OKAY, EXOKAY, SLVERR, DECERR.
  - `wr_state_t` and `rd_state_t` enums.
  - Helper function `next_addr(addr, size, burst)`.
- One sub-module, `axi_hp_mem_ram`: a simple dual-port RAM (`2^AD`×64) with a byte-enabled synchronous write port and a registered read port, inferable as BRAM.
- The top module holds the two FSMs, the beat counters and the error logic.

## Test plan
- **Single write then read:** AW addr=BASE+0x10, len=0, size=3, INCR; W data=64'hDEAD_BEEF_0123_4567, strb=8'hFF → BRESP=OKAY. Then AR at the same address → RDATA=64'hDEAD_BEEF_0123_4567, RLAST=1, RRESP=OKAY, RVALID one cycle after the AR handshake.
- **16-beat INCR burst:**
  - Write data i, i=0..15, at BASE.
  - Read back with RREADY toggling 1/0 every cycle: 16 beats in order, RDATA stable while stalled, RLAST only on beat 15, RID = ARID.
- **Byte strobes:** fill a word with all-ones, then write 0 with strb=8'h0F → read returns 64'hFFFF_FFFF_0000_0000.
- **Errors:**
  - A WRAP burst and a burst starting at BASE + 2^AD·8 each give BRESP=SLVERR with memory unchanged.
  - A read of an out-of-range address returns RRESP=SLVERR with RDATA=0.
  - WLAST asserted on beat 1 of a 4-beat burst → 4 beats still accepted, BRESP=SLVERR.
- **Concurrent read/write:** read and write bursts on the same word in the same cycle → the read returns the old value, and a subsequent read returns the new value.
- **Reset mid-burst:** drop ARESETn during beat 3 of 8 → all valid/ready outputs are 0 within the same cycle. After release, AWREADY=ARREADY=1, and the beats committed before the reset are still readable.
